// File: rtl/jelly_burst_last_generator.sv
// Tags a beat stream with burst-end and transfer-end flags, using the burst
// commands (len, last) issued alongside the address bursts.
module jelly_burst_last_generator #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter bit LEN_OFFSET = 1'b1,
    parameter int USER_WIDTH = 0,
    localparam int USER_BITS = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,

    input  logic [LEN_WIDTH-1:0]  s_cmd_len,
    input  logic                  s_cmd_last,
    input  logic                  s_cmd_valid,
    output logic                  s_cmd_ready,

    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [USER_BITS-1:0]  s_user,
    input  logic                  s_valid,
    output logic                  s_ready,

    output logic [DATA_WIDTH-1:0] m_data,
    output logic [USER_BITS-1:0]  m_user,
    output logic                  m_burst_last,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int CW = LEN_WIDTH + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   cmd_len;
    logic                   cmd_last;
    logic [CW-1:0]          cnt;

    logic                   cmd_active;
    logic                   out_ready;
    logic                   beat_acc;
    logic                   cmd_acc;
    logic [CW-1:0]          last_index;
    logic                   beat_is_last;

    // One extra bit keeps the offset length from wrapping at maximum len.
    assign last_index   = {1'b0, cmd_len} + CW'(LEN_OFFSET) - CW'(1);
    assign beat_is_last = (cnt == last_index);

    assign cmd_active   = (state == BURST);
    assign out_ready    = !m_valid || m_ready;
    assign s_ready      = cmd_active && out_ready;
    assign beat_acc     = s_valid && s_ready;
    assign s_cmd_ready  = !cmd_active || (beat_acc && beat_is_last);
    assign cmd_acc      = s_cmd_valid && s_cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            m_valid <= 1'b0;
        end else if (cke) begin
            if (beat_acc) begin
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            // A command accepted on the final beat takes precedence.
            if (cmd_acc) begin
                state <= BURST;
                cnt   <= '0;
            end else if (beat_acc) begin
                if (beat_is_last) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cke) begin
            if (cmd_acc) begin
                cmd_len  <= s_cmd_len;
                cmd_last <= s_cmd_last;
            end
            if (beat_acc) begin
                m_data       <= s_data;
                m_user       <= s_user;
                m_burst_last <= beat_is_last;
                m_last       <= beat_is_last && cmd_last;
            end
        end
    end

endmodule

// File: tb/tb_jelly_burst_last_generator.sv
// Self-checking bench: directed cycle tables, hand sequences and randomized
// streams checked against a beat-list model built from the command list.
module tb_jelly_burst_last_generator;

    localparam int DW = 16;
    localparam int LW = 4;
    localparam int UW = 4;

    logic          reset, clk, cke;
    logic [LW-1:0] s_cmd_len;
    logic          s_cmd_last, s_cmd_valid, s_cmd_ready;
    logic [DW-1:0] s_data;
    logic [UW-1:0] s_user;
    logic          s_valid, s_ready;
    logic [DW-1:0] m_data;
    logic [UW-1:0] m_user;
    logic          m_burst_last, m_last, m_valid, m_ready;

    int tests = 0;
    int fails = 0;

    jelly_burst_last_generator #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .LEN_OFFSET (1'b1),
        .USER_WIDTH (UW)
    ) dut (
        .reset        (reset),
        .clk          (clk),
        .cke          (cke),
        .s_cmd_len    (s_cmd_len),
        .s_cmd_last   (s_cmd_last),
        .s_cmd_valid  (s_cmd_valid),
        .s_cmd_ready  (s_cmd_ready),
        .s_data       (s_data),
        .s_user       (s_user),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_user       (m_user),
        .m_burst_last (m_burst_last),
        .m_last       (m_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic          cv;
        logic [LW-1:0] len;
        logic          cl;
        logic          sv;
        logic [DW-1:0] d;
        logic          mr;
        logic          e_cr;
        logic          e_sr;
        logic          e_mv;
        logic [DW-1:0] e_d;
        logic          e_bl;
        logic          e_ml;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic cv, input logic [LW-1:0] len, input logic cl,
                       input logic sv, input logic [DW-1:0] d, input logic mr,
                       input logic e_cr, input logic e_sr, input logic e_mv,
                       input logic [DW-1:0] e_d, input logic e_bl, input logic e_ml);
        vec_t v;
        v.cv = cv; v.len = len; v.cl = cl; v.sv = sv; v.d = d; v.mr = mr;
        v.e_cr = e_cr; v.e_sr = e_sr; v.e_mv = e_mv; v.e_d = e_d; v.e_bl = e_bl; v.e_ml = e_ml;
        vecs.push_back(v);
    endtask

    // Command list consumed by run_stream.
    int cmd_len_q[$];
    bit cmd_last_q[$];

    task automatic run_stream(input bit rv, input bit rr, input bit rc, input int budget);
        logic [DW-1:0] din[$];
        bit ebl[$];
        bit eml[$];
        int total, ci, di, oi, cyc, ncmd;
        bit cv_hold, sv_hold, cacc, bacc, oacc, prev_hold;
        logic [DW-1:0] pd;
        logic [UW-1:0] pu;
        logic pbl, pml;

        // Model: each command contributes len+1 beats, the final one flagged.
        ncmd = cmd_len_q.size();
        for (int c = 0; c < ncmd; c++) begin
            int n = cmd_len_q[c] + 1;
            for (int j = 0; j < n; j++) begin
                din.push_back(DW'($urandom));
                ebl.push_back(j == n - 1);
                eml.push_back((j == n - 1) && cmd_last_q[c]);
            end
        end
        total = din.size();
        ci = 0; di = 0; oi = 0; cyc = 0;
        cv_hold = 0; sv_hold = 0; cacc = 0; bacc = 0; prev_hold = 0;
        pd = '0; pu = '0; pbl = 0; pml = 0;

        while (oi < total && cyc < budget) begin
            @(negedge clk);
            if (cacc) ci++;
            if (bacc) di++;
            if (ci < ncmd) begin
                if (!cv_hold) s_cmd_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
                s_cmd_len  = LW'(cmd_len_q[ci]);
                s_cmd_last = cmd_last_q[ci];
            end else begin
                s_cmd_valid = 1'b0;
            end
            if (di < total) begin
                if (!sv_hold) s_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
                s_data = din[di];
                s_user = din[di][7:4];
            end else begin
                s_valid = 1'b0;
            end
            m_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            cke     = rc ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (prev_hold) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(pd));
                check("hold_user", 32'(m_user), 32'(pu));
                check("hold_flags", {30'd0, m_burst_last, m_last}, {30'd0, pbl, pml});
            end
            if (m_valid && !m_ready) check("bp_s_ready", 32'(s_ready), 32'd0);
            oacc = cke && m_valid && m_ready;
            if (oacc) begin
                check("out_data", 32'(m_data), 32'(din[oi]));
                check("out_user", 32'(m_user), 32'(din[oi][7:4]));
                check("out_burst_last", 32'(m_burst_last), 32'(ebl[oi]));
                check("out_last", 32'(m_last), 32'(eml[oi]));
                oi++;
            end
            prev_hold = m_valid && !oacc;
            pd = m_data; pu = m_user; pbl = m_burst_last; pml = m_last;
            cacc = cke && s_cmd_valid && s_cmd_ready;
            bacc = cke && s_valid && s_ready;
            cv_hold = s_cmd_valid && !cacc;
            sv_hold = s_valid && !bacc;
            cyc++;
        end
        if (oi < total) check("stream_timeout", 32'(oi), 32'(total));
        @(negedge clk);
        s_cmd_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b1; cke = 1'b1;
        cmd_len_q.delete();
        cmd_last_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cke = 1'b1;
        s_cmd_len = '0; s_cmd_last = 1'b0; s_cmd_valid = 1'b0;
        s_data = '0; s_user = '0; s_valid = 1'b0; m_ready = 1'b1;

        // Single burst len=3: latency, flags, command ready on last accept.
        add(1,3,1, 1,16'hB000,1, 1,0,0, 16'h0,0,0);
        add(0,0,0, 1,16'hB000,1, 0,1,0, 16'h0,0,0);
        add(0,0,0, 1,16'hB001,1, 0,1,1, 16'hB000,0,0);
        add(0,0,0, 1,16'hB002,1, 0,1,1, 16'hB001,0,0);
        add(0,0,0, 1,16'hB003,1, 1,1,1, 16'hB002,0,0);
        add(0,0,0, 0,16'h0000,1, 1,0,1, 16'hB003,1,1);
        add(0,0,0, 0,16'h0000,1, 1,0,0, 16'h0,0,0);
        // Back-to-back bursts len=1/last=0 then len=2/last=1.
        add(1,1,0, 1,16'hA000,1, 1,0,0, 16'h0,0,0);
        add(1,2,1, 1,16'hA000,1, 0,1,0, 16'h0,0,0);
        add(1,2,1, 1,16'hA001,1, 1,1,1, 16'hA000,0,0);
        add(0,0,0, 1,16'hA002,1, 0,1,1, 16'hA001,1,0);
        add(0,0,0, 1,16'hA003,1, 0,1,1, 16'hA002,0,0);
        add(0,0,0, 1,16'hA004,1, 1,1,1, 16'hA003,0,0);
        add(0,0,0, 0,16'h0000,1, 1,0,1, 16'hA004,1,1);
        add(0,0,0, 0,16'h0000,1, 1,0,0, 16'h0,0,0);
        // Single-beat burst held by output backpressure.
        add(1,0,0, 1,16'hC000,0, 1,0,0, 16'h0,0,0);
        add(0,0,0, 1,16'hC000,0, 1,1,0, 16'h0,0,0);
        add(0,0,0, 0,16'h0000,0, 1,0,1, 16'hC000,1,0);
        add(0,0,0, 0,16'h0000,0, 1,0,1, 16'hC000,1,0);
        add(0,0,0, 0,16'h0000,1, 1,0,1, 16'hC000,1,0);
        add(0,0,0, 0,16'h0000,1, 1,0,0, 16'h0,0,0);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_cmd_ready", 32'(s_cmd_ready), 32'd1);
        check("reset_s_ready", 32'(s_ready), 32'd0);
        check("reset_m_valid", 32'(m_valid), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            s_cmd_valid = vecs[i].cv; s_cmd_len = vecs[i].len; s_cmd_last = vecs[i].cl;
            s_valid = vecs[i].sv; s_data = vecs[i].d; s_user = vecs[i].d[3:0];
            m_ready = vecs[i].mr;
            #1;
            check($sformatf("vec%0d_cmd_ready", i), 32'(s_cmd_ready), 32'(vecs[i].e_cr));
            check($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].e_sr));
            check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
            if (vecs[i].e_mv) begin
                check($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].e_d));
                check($sformatf("vec%0d_m_user", i), 32'(m_user), 32'(vecs[i].e_d[3:0]));
                check($sformatf("vec%0d_burst_last", i), 32'(m_burst_last), 32'(vecs[i].e_bl));
                check($sformatf("vec%0d_last", i), 32'(m_last), 32'(vecs[i].e_ml));
            end
        end

        // Maximum length: 16 beats, single burst-end flag.
        cmd_len_q.push_back(15); cmd_last_q.push_back(1);
        run_stream(0, 0, 0, 200);

        // len=7 with random output stalls.
        cmd_len_q.push_back(7); cmd_last_q.push_back(1);
        run_stream(0, 1, 0, 500);

        // Data offered with no command: must be held upstream.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_cmd_valid = 1'b0; s_valid = 1'b1; s_data = DW'(16'hD000 + i); m_ready = 1'b1;
            #1;
            check("nocmd_s_ready", 32'(s_ready), 32'd0);
            check("nocmd_m_valid", 32'(m_valid), 32'd0);
        end
        cmd_len_q.push_back(0); cmd_last_q.push_back(1);
        cmd_len_q.push_back(0); cmd_last_q.push_back(0);
        run_stream(0, 0, 0, 100);

        // Reset after 2 of 4 beats, with the output stalled.
        @(negedge clk);
        s_cmd_valid = 1'b1; s_cmd_len = 4'd3; s_cmd_last = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        s_cmd_valid = 1'b0; s_valid = 1'b1; s_data = 16'h1111; s_user = 4'h1;
        @(negedge clk);
        s_data = 16'h2222; s_user = 4'h2;
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_m_valid", 32'(m_valid), 32'd0);
        check("midreset_cmd_ready", 32'(s_cmd_ready), 32'd1);
        check("midreset_s_ready", 32'(s_ready), 32'd0);
        cmd_len_q.push_back(1); cmd_last_q.push_back(0);
        run_stream(0, 0, 0, 100);

        // Randomized commands, valids, stalls and clock enable.
        for (int i = 0; i < 30; i++) begin
            cmd_len_q.push_back($urandom_range(0, 15));
            cmd_last_q.push_back(1'($urandom_range(0, 1)));
        end
        run_stream(1, 1, 1, 20000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jelly_burst_last_generator.md
Name: jelly_burst_last_generator

Overview:
- Sits directly downstream of the burst address generator.
- Consumes its burst commands (len, last) and a beat-level data stream.
- Tags every data beat with a burst-end flag (for AXI WLAST) and a transfer-end flag (end of the final burst).
- Lets write-data channels stay aligned to the generated address bursts without per-beat bookkeeping upstream.

Parameters:
- DATA_WIDTH, 32, data beat width.
- LEN_WIDTH, 8, width of command length field.
- LEN_OFFSET, 1'b1, beats in a burst = s_cmd_len + LEN_OFFSET (AXI encoding when 1).
- USER_WIDTH, 0, optional per-beat sideband passed through unchanged; 0 = absent, internal width is max(USER_WIDTH,1).

Ports:
- reset  input  1  synchronous, active-high reset
- clk  input  1  clock
- cke  input  1  clock enable; when low, all state holds
- s_cmd_len  input  LEN_WIDTH  burst length, offset-encoded
- s_cmd_last  input  1  this burst is the final burst of the transfer
- s_cmd_valid  input  1  command valid
- s_cmd_ready  output  1  command accepted
- s_data  input  DATA_WIDTH  data beat
- s_user  input  max(USER_WIDTH,1)  sideband
- s_valid  input  1  beat valid
- s_ready  output  1  beat accepted
- m_data  output  DATA_WIDTH  registered data beat
- m_user  output  max(USER_WIDTH,1)  registered sideband
- m_burst_last  output  1  beat is last of its burst
- m_last  output  1  beat is last of the final burst
- m_valid  output  1  output valid
- m_ready  input  1  output accepted

Behaviour:
- Reset: cmd_active=0, beat counter=0, m_valid=0. m_data, m_user, m_burst_last and m_last are don't-care (x) after reset. s_cmd_ready=1 and s_ready=0 immediately after reset.
- State: cmd_active flag, latched cmd_len and cmd_last, beat counter cnt of LEN_WIDTH+1 bits, so the offset length never overflows.
- States:
  - IDLE (cmd_active=0).
  - BURST (cmd_active=1).
- Output register:
  - out_ready = !m_valid || m_ready.
  - s_ready = cmd_active && out_ready.
  - beat_acc = s_valid && s_ready.
- beat_is_last = ({1'b0,cnt} == {1'b0,cmd_len} + LEN_OFFSET - 1), compared at LEN_WIDTH+1 bits.
- s_cmd_ready = !cmd_active || (beat_acc && beat_is_last). This allows back-to-back bursts with zero bubble.
- On beat_acc, registered for 1-cycle latency:
  - m_data <= s_data
  - m_user <= s_user
  - m_burst_last <= beat_is_last
  - m_last <= beat_is_last && cmd_last
  - m_valid <= 1
- On m_ready && m_valid with no beat_acc: m_valid <= 0.
- Counter:
  - beat_acc && !beat_is_last: cnt <= cnt+1.
  - beat_acc && beat_is_last: cnt <= 0, cmd_active <= 0, unless a command is accepted the same cycle.
- Command acceptance (s_cmd_valid && s_cmd_ready): latch len/last, cmd_active <= 1, cnt <= 0.
- Simultaneous last beat and new command: the new command wins, cmd_active stays 1, and the next beat counts as beat 0 of the new burst.
- LEN_OFFSET=0 with s_cmd_len=0 is a zero-beat burst. It is illegal input; behaviour is undefined and it must not hang the bench's reset recovery.
- Maximum length: s_cmd_len=2^LEN_WIDTH-1 with LEN_OFFSET=1 gives 2^LEN_WIDTH beats. This works because of the extra counter bit.
- Data before any command: s_ready stays 0 and the beat is held upstream.
- Backpressure: while m_valid && !m_ready, s_ready=0. Held outputs stay stable, and cnt and cmd_active do not change.
- Reset mid-burst: state returns to IDLE next cycle, any partial burst is discarded, and m_valid=0.
- cke=0: no register updates. Ready outputs still reflect current state, but no transfer is counted.

Test Plan:
- Single burst, s_cmd_len=3, last=1, LEN_OFFSET=1, 4 beats D0..D3, m_ready=1 → m_burst_last only on D3, m_last only on D3, 1-cycle latency, s_cmd_ready returns high on D3 accept.
- Two commands len=1,last=0 then len=2,last=1, continuous data of 5 beats → burst_last on beats 1 and 4, m_last on beat 4, no idle cycle between bursts, s_cmd_ready high on the cycle beat 1 is accepted.
- Max length LEN_WIDTH=4, s_cmd_len=15 → exactly 16 beats, burst_last only on beat 15, counter does not wrap early.
- Random m_ready toggling (50%) with len=7 → m_data and flags stay stable while stalled, no beat lost or duplicated, burst_last on the 8th output.
- Data valid with no command for 10 cycles → s_ready=0 throughout, m_valid=0. Then command len=0 → next beat is emitted with burst_last=1 and m_last=cmd_last.
- Reset asserted after 2 of 4 beats → m_valid=0 and s_cmd_ready=1 next cycle. A new command len=1 then produces burst_last on its 2nd beat.
